// File: rtl/ps2_rx_if.sv
// PS/2 receiver port bundle: raw line inputs, received-byte outputs and FSM state for debug.
// rx_done/frame_err are single-cycle strobes with no back-pressure; a consumer must latch dout on rx_done.
interface ps2_rx_if;
    logic       PS2C;
    logic       PS2D;
    logic [7:0] dout;
    logic       rx_done;
    logic       frame_err;
    logic       busy;
    logic [1:0] state_dbg;

    modport master (
        output PS2C, PS2D,
        input  dout, rx_done, frame_err, busy, state_dbg
    );

    modport slave (
        input  PS2C, PS2D,
        output dout, rx_done, frame_err, busy, state_dbg
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises and filters PS2C, deserialises
// start/8 data/odd parity/stop frames and strobes one validated byte per frame.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic     clk,
    input  logic     reset,
    ps2_rx_if.slave  bus
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abort fires on the cycle the counter would step onto TIMEOUT-1.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CHECK = 2'd2} state_t;

    logic                  r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk;
    logic                  r_fall;

    state_t                r_state;
    logic [3:0]            r_bit_cnt;
    logic [TW-1:0]         r_to_cnt;
    logic [9:0]            r_shift;
    logic [7:0]            r_dout;
    logic                  r_rx_done;
    logic                  r_frame_err;
    logic                  r_busy;
    logic                  w_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_s1 <= 1'b1;
            r_c_s2 <= 1'b1;
            r_d_s1 <= 1'b1;
            r_d_s2 <= 1'b1;
            r_filt <= '1;
            r_fclk <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_c_s1 <= bus.PS2C;
            r_c_s2 <= r_c_s1;
            r_d_s1 <= bus.PS2D;
            r_d_s2 <= r_d_s1;
            r_filt <= {r_filt[FILTER_LEN-2:0], r_c_s2};
            if (&r_filt)
                r_fclk <= 1'b1;
            else if (~|r_filt)
                r_fclk <= 1'b0;
            r_fall <= r_fclk && (~|r_filt);
        end
    end

    // Odd parity over data plus parity bit, and a high stop bit.
    assign w_valid = (^r_shift[8:0]) && r_shift[9];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 4'd0;
            r_to_cnt    <= '0;
            r_shift     <= 10'd0;
            r_dout      <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_fall && !r_d_s2) begin
                        r_state   <= RECV;
                        r_bit_cnt <= 4'd0;
                        r_to_cnt  <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                RECV: begin
                    if (r_fall) begin
                        r_shift   <= {r_d_s2, r_shift[9:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_to_cnt  <= '0;
                        if (r_bit_cnt == 4'd9)
                            r_state <= CHECK;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (w_valid) begin
                        r_dout    <= r_shift[7:0];
                        r_rx_done <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout      = r_dout;
    assign bus.rx_done   = r_rx_done;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx with FILTER_LEN=4, TIMEOUT=1000 and a 200-cycle PS/2 bit period.
// Outputs are sampled on the falling clock edge; a monitor counts strobes and records when they occur.
module tb_ps2_rx;
    logic clk;
    logic reset;
    int   cyc;
    int   n_assert;
    int   n_fail;

    int   n_done, n_err, n_both;
    int   done_cyc, err_cyc;
    logic done_busy, err_busy;
    int   edge_cyc;
    int   base_done, base_err;

    ps2_rx_if bus();

    ps2_rx #(.FILTER_LEN(4), .TIMEOUT(1000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor
    initial begin
        n_done = 0; n_err = 0; n_both = 0;
        done_cyc = 0; err_cyc = 0;
        done_busy = 1'b0; err_busy = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.rx_done === 1'b1) begin
            n_done++;
            done_cyc  = cyc;
            done_busy = bus.busy;
        end
        if (bus.frame_err === 1'b1) begin
            n_err++;
            err_cyc  = cyc;
            err_busy = bus.busy;
        end
        if (bus.rx_done === 1'b1 && bus.frame_err === 1'b1)
            n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data settles mid high half, then 100 cycles low, 100 high.
    task automatic send_bit(input logic b);
        bus.PS2D = b;
        wait_cyc(50);
        bus.PS2C = 1'b0;
        edge_cyc = cyc;
        wait_cyc(100);
        bus.PS2C = 1'b1;
        wait_cyc(50);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ par_flip);
        send_bit(stop);
    endtask

    task automatic mark();
        base_done = n_done;
        base_err  = n_err;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        edge_cyc = 0;
        bus.PS2C = 1'b1;
        bus.PS2D = 1'b1;

        // 1. reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_dout", {24'd0, bus.dout}, 32'h00);
        check("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_state", {30'd0, bus.state_dbg}, 32'd0);

        // 2. single 0x1C frame; busy rises after the start edge
        mark();
        bus.PS2D = 1'b0;
        wait_cyc(50);
        bus.PS2C = 1'b0;
        wait_cyc(20);
        check("start_busy", {31'd0, bus.busy}, 32'd1);
        wait_cyc(80);
        bus.PS2C = 1'b1;
        wait_cyc(50);
        for (int i = 0; i < 8; i++) send_bit(logic'(8'h1C >> i));
        send_bit(1'b0);
        send_bit(1'b1);
        check("1c_done_cnt", n_done - base_done, 32'd1);
        check("1c_err_cnt", n_err - base_err, 32'd0);
        check("1c_dout", {24'd0, bus.dout}, 32'h1C);
        // 2 sync + 4 filter + 1 edge-detect cycles to fall_edge, then two more to the strobe
        check("1c_latency", done_cyc - edge_cyc, 32'd9);
        check("1c_busy_at_strobe", {31'd0, done_busy}, 32'd0);
        check("1c_busy_after", {31'd0, bus.busy}, 32'd0);

        // 3. back-to-back 0xF0 then 0x1C with a 300-cycle gap
        mark();
        send_frame(8'hF0, 1'b0, 1'b1);
        check("f0_done_cnt", n_done - base_done, 32'd1);
        check("f0_dout", {24'd0, bus.dout}, 32'hF0);
        wait_cyc(300);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("pair_done_cnt", n_done - base_done, 32'd2);
        check("pair_err_cnt", n_err - base_err, 32'd0);
        check("pair_dout", {24'd0, bus.dout}, 32'h1C);

        // 4. parity error, then stop error
        mark();
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_err_cnt", n_err - base_err, 32'd1);
        check("par_err_latency", err_cyc - edge_cyc, 32'd9);
        check("par_err_busy", {31'd0, err_busy}, 32'd0);
        check("par_done_cnt", n_done - base_done, 32'd0);
        check("par_dout_kept", {24'd0, bus.dout}, 32'h1C);
        wait_cyc(100);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("stop_err_cnt", n_err - base_err, 32'd2);
        check("stop_done_cnt", n_done - base_done, 32'd0);
        check("stop_dout_kept", {24'd0, bus.dout}, 32'h1C);

        // 5. 2-cycle clock glitch and a high-data edge, both in IDLE
        mark();
        bus.PS2D = 1'b0;
        wait_cyc(20);
        bus.PS2C = 1'b0;
        wait_cyc(2);
        bus.PS2C = 1'b1;
        wait_cyc(30);
        check("glitch_busy", {31'd0, bus.busy}, 32'd0);
        check("glitch_state", {30'd0, bus.state_dbg}, 32'd0);
        send_bit(1'b1);
        check("hi_edge_busy", {31'd0, bus.busy}, 32'd0);
        wait_cyc(1100);
        check("idle_noise_strobes", (n_done - base_done) + (n_err - base_err), 32'd0);

        // 6a. timeout after start + 3 data bits
        mark();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("partial_busy", {31'd0, bus.busy}, 32'd1);
        wait_cyc(1100);
        check("to_err_cnt", n_err - base_err, 32'd1);
        // 7 cycles to fall_edge, then 1000 cycles of silence
        check("to_latency", err_cyc - edge_cyc, 32'd1007);
        check("to_busy", {31'd0, bus.busy}, 32'd0);
        check("to_done_cnt", n_done - base_done, 32'd0);
        check("to_dout_kept", {24'd0, bus.dout}, 32'h1C);

        mark();
        send_frame(8'h29, 1'b0, 1'b1);
        check("29_done_cnt", n_done - base_done, 32'd1);
        check("29_dout", {24'd0, bus.dout}, 32'h29);

        // 6b. reset after data bit 5
        mark();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(logic'(8'hF0 >> i));
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_state", {30'd0, bus.state_dbg}, 32'd0);
        check("mid_rst_dout", {24'd0, bus.dout}, 32'h00);
        wait_cyc(1100);
        check("mid_rst_strobes", (n_done - base_done) + (n_err - base_err), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("post_rst_done_cnt", n_done - base_done, 32'd1);
        check("post_rst_dout", {24'd0, bus.dout}, 32'hF0);

        check("never_both", n_both, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
